// File: rtl/button_evt_pkg.sv
// -----------------------------------------------------------------------------
// button_evt_pkg
// Shared definitions for the push-button gesture decoder:
//   - 3-bit FSM state encoding (IDLE=0, PRESSED=1, LONG_HELD=2, GAP=3, SECOND=4)
//   - default timing constants for a 100 MHz clock
// No ports (package).
// -----------------------------------------------------------------------------
package button_evt_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_PRESSED   = 3'd1;
    localparam logic [2:0] ST_LONG_HELD = 3'd2;
    localparam logic [2:0] ST_GAP       = 3'd3;
    localparam logic [2:0] ST_SECOND    = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        PRESSED   = ST_PRESSED,
        LONG_HELD = ST_LONG_HELD,
        GAP       = ST_GAP,
        SECOND    = ST_SECOND
    } state_e;

    // 1 s long press and 300 ms double-press window at 100 MHz.
    localparam int unsigned DEFAULT_LONG_CYCLES = 32'd100000000;
    localparam int unsigned DEFAULT_GAP_CYCLES  = 32'd30000000;
    localparam int unsigned DEFAULT_CNT_W       = 32'd27;

endpackage : button_evt_pkg

// File: rtl/edge_detect.sv
// -----------------------------------------------------------------------------
// edge_detect
// Delays the debounced button level by one clock and flags its edges.
// Ports:
//   clk   in  : clock
//   rst   in  : asynchronous active-high reset (delayed level clears to 0)
//   level in  : debounced button level, synchronous to clk
//   rise  out : combinational, level is 1 and was 0 last cycle
//   fall  out : combinational, level is 0 and was 1 last cycle
// Because the delayed level resets to 0, a button held through reset
// release produces a rise on the first sampled cycle.
// -----------------------------------------------------------------------------
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise,
    output logic fall
);

    logic pb_d_r;

    // One-cycle delayed copy of the button level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pb_d_r <= 1'b0;
        end else begin
            pb_d_r <= level;
        end
    end

    assign rise = level & ~pb_d_r;
    assign fall = ~level & pb_d_r;

endmodule : edge_detect

// File: rtl/button_event_decoder.sv
// -----------------------------------------------------------------------------
// button_event_decoder
// Turns the debounced push-button level into single-cycle gesture pulses.
//
// Compile-time option: define BUTTON_DOUBLE_PRESS_EN to enable double-press
// detection (adds the GAP and SECOND states; short presses are then reported
// only once the double-press window has expired).
//
// Parameters:
//   LONG_CYCLES : hold length in cycles that makes a long press
//   GAP_CYCLES  : max release-to-second-press gap (double-press build only)
//   CNT_W       : counter width, 2**CNT_W > max(LONG_CYCLES, GAP_CYCLES)
// Ports:
//   clk          in  : clock, shared with the debouncer
//   rst          in  : asynchronous active-high reset
//   pb_state     in  : debounced level, 1 = pressed
//   press        out : pulse, one cycle after a 0->1 edge is sampled
//   release_evt  out : pulse, one cycle after a 1->0 edge is sampled
//                      ("release" is a reserved word in SystemVerilog)
//   short_press  out : pulse for a completed short single press
//   long_press   out : pulse when a hold reaches LONG_CYCLES
//   double_press out : pulse on the second press of a double press
//                      (constant 0 without BUTTON_DOUBLE_PRESS_EN)
//   held         out : level, 1 while in LONG_HELD
// All outputs are registered and clear asynchronously on reset.
// -----------------------------------------------------------------------------
module button_event_decoder
    import button_evt_pkg::*;
#(
    parameter int unsigned LONG_CYCLES = DEFAULT_LONG_CYCLES,
    parameter int unsigned GAP_CYCLES  = DEFAULT_GAP_CYCLES,
    parameter int unsigned CNT_W       = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_state,
    output logic press,
    output logic release_evt,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic held
);

    // Reject counter widths that could wrap before a terminal count.
    localparam longint unsigned CNT_SPAN = 64'd1 << CNT_W;
    if ((64'(LONG_CYCLES) >= CNT_SPAN) || (64'(GAP_CYCLES) >= CNT_SPAN) ||
        (LONG_CYCLES == 32'd0) || (GAP_CYCLES == 32'd0)) begin : g_bad_cfg
        $error("button_event_decoder: CNT_W too small or zero timing constant");
    end

    localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYCLES - 32'd1);
`ifdef BUTTON_DOUBLE_PRESS_EN
    localparam logic [CNT_W-1:0] GAP_TERM  = CNT_W'(GAP_CYCLES - 32'd1);
`endif
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);

    state_e           state_r;
    state_e           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             rise_s;
    logic             fall_s;
    logic             short_s;
    logic             long_s;
    logic             double_s;
    logic             held_s;

    edge_detect u_edge_detect (
        .clk   (clk),
        .rst   (rst),
        .level (pb_state),
        .rise  (rise_s),
        .fall  (fall_s)
    );

    // Next-state, counter and gesture decode. Edges take priority over
    // terminal counts so a boundary release stays short and a boundary
    // second press still counts as a double press.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        short_s  = 1'b0;
        long_s   = 1'b0;
        double_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (rise_s) begin
                    state_s = PRESSED;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = IDLE;
                end
            end
            PRESSED: begin
                if (fall_s) begin
`ifdef BUTTON_DOUBLE_PRESS_EN
                    state_s = GAP;
                    cnt_s   = CNT_ZERO;
`else
                    short_s = 1'b1;
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
`endif
                end else if (cnt_r == LONG_TERM) begin
                    long_s  = 1'b1;
                    state_s = LONG_HELD;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            LONG_HELD: begin
                if (fall_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = LONG_HELD;
                end
            end
`ifdef BUTTON_DOUBLE_PRESS_EN
            GAP: begin
                if (rise_s) begin
                    double_s = 1'b1;
                    state_s  = SECOND;
                    cnt_s    = CNT_ZERO;
                end else if (cnt_r == GAP_TERM) begin
                    short_s  = 1'b1;
                    state_s  = IDLE;
                    cnt_s    = CNT_ZERO;
                end else begin
                    cnt_s    = cnt_r + CNT_ONE;
                end
            end
            SECOND: begin
                // The second press of a double is never timed as a long press.
                if (fall_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = SECOND;
                end
            end
`endif
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
        held_s = (state_s == LONG_HELD);
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Registered event outputs; held tracks the registered state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press        <= 1'b0;
            release_evt  <= 1'b0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_press <= 1'b0;
            held         <= 1'b0;
        end else begin
            press        <= rise_s;
            release_evt  <= fall_s;
            short_press  <= short_s;
            long_press   <= long_s;
            double_press <= double_s;
            held         <= held_s;
        end
    end

endmodule : button_event_decoder

// File: tb/tb_button_event_decoder.sv
// -----------------------------------------------------------------------------
// tb_button_event_decoder
// Directed and random stimulus for button_event_decoder with LONG_CYCLES=20,
// GAP_CYCLES=10, CNT_W=5. Expected outputs come from a timestamp-based
// gesture model: each press/release is stamped with its sample index and the
// gesture pulses are derived from the distances between those stamps.
// Honors BUTTON_DOUBLE_PRESS_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_button_event_decoder;

    localparam int L = 20;
    localparam int G = 10;

    logic clk = 1'b0;
    logic rst;
    logic pb_state;
    logic press, release_evt, short_press, long_press, double_press, held;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Model state: sample index, previous level, timestamps of the open
    // first press and of the release that opened a double-press window.
    int   n_edge = 0;
    logic m_prev;
    int   m_press_at;
    int   m_release_at;
    bit   m_long;
    bit   m_second;
    logic exp_press, exp_release, exp_short, exp_long, exp_double, exp_held;

    button_event_decoder #(
        .LONG_CYCLES (L),
        .GAP_CYCLES  (G),
        .CNT_W       (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pb_state     (pb_state),
        .press        (press),
        .release_evt  (release_evt),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_press (double_press),
        .held         (held)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_prev       = 1'b0;
        m_press_at   = -1;
        m_release_at = -1;
        m_long       = 1'b0;
        m_second     = 1'b0;
        exp_press    = 1'b0;
        exp_release  = 1'b0;
        exp_short    = 1'b0;
        exp_long     = 1'b0;
        exp_double   = 1'b0;
        exp_held     = 1'b0;
    endtask

    // Expected outputs after the clock edge that samples level 'cur'.
    task automatic model_step(input logic cur);
        logic rise, fall;
        rise        = cur & ~m_prev;
        fall        = ~cur & m_prev;
        exp_press   = rise;
        exp_release = fall;
        exp_short   = 1'b0;
        exp_long    = 1'b0;
        exp_double  = 1'b0;
        if (m_press_at >= 0) begin
            // A release no later than L samples after the press is short.
            if (fall) begin
`ifdef BUTTON_DOUBLE_PRESS_EN
                m_release_at = n_edge;
`else
                exp_short = 1'b1;
`endif
                m_press_at = -1;
            end else if (n_edge == m_press_at + L) begin
                exp_long   = 1'b1;
                m_long     = 1'b1;
                m_press_at = -1;
            end
        end else if (m_long) begin
            if (fall) m_long = 1'b0;
        end else if (m_release_at >= 0) begin
            // Second press within G samples of the release is a double.
            if (rise) begin
                exp_double   = 1'b1;
                m_second     = 1'b1;
                m_release_at = -1;
            end else if (n_edge == m_release_at + G) begin
                exp_short    = 1'b1;
                m_release_at = -1;
            end
        end else if (m_second) begin
            if (fall) m_second = 1'b0;
        end else if (rise) begin
            m_press_at = n_edge;
        end
        exp_held = m_long;
        m_prev   = cur;
    endtask

    task automatic check_all(input string tag);
        logic [5:0] obs, exp;
        obs = {press, release_evt, short_press, long_press, double_press, held};
        exp = {exp_press, exp_release, exp_short, exp_long, exp_double, exp_held};
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s sample=%0d observed(p,r,s,l,d,h)=%b expected=%b",
                   tag, n_edge, obs, exp);
        end
    endtask

    task automatic step(input logic v, input string tag);
        pb_state = v;
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(v);
        n_edge++;
        #1 check_all(tag);
    endtask

    task automatic hold(input logic v, input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) step(v, tag);
    endtask

    // Mid-cycle asynchronous reset, held for 'edges' clock edges.
    task automatic pulse_reset(input int edges, input logic v, input string tag);
        #2 rst = 1'b1;
        model_reset();
        #1 check_all({tag, "_async"});
        hold(v, edges, tag);
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        pb_state = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_all("reset_state");
        rst = 1'b0;

        // 1: short single press
        hold(1'b1, 5, "s1_high");
        hold(1'b0, 25, "s1_low");
        // 2: long hold
        hold(1'b1, 30, "s2_hold");
        hold(1'b0, 25, "s2_low");
        // 3: press 5, release 4, press 5
        hold(1'b1, 5, "s3_p1");
        hold(1'b0, 4, "s3_gap");
        hold(1'b1, 5, "s3_p2");
        hold(1'b0, 25, "s3_low");
        // 4: short press, gap expiry
        hold(1'b1, 5, "s4_high");
        hold(1'b0, 25, "s4_low");
        // 5a: second rise on the last gap cycle
        hold(1'b1, 5, "s5a_p1");
        hold(1'b0, G, "s5a_gap");
        hold(1'b1, 5, "s5a_p2");
        hold(1'b0, 25, "s5a_low");
        // 5b: second rise one cycle after the gap expires
        hold(1'b1, 5, "s5b_p1");
        hold(1'b0, G + 1, "s5b_gap");
        hold(1'b1, 5, "s5b_p2");
        hold(1'b0, 25, "s5b_low");
        // 5c: fall on the long-terminal cycle, then one cycle later
        hold(1'b1, L, "s5c_high");
        hold(1'b0, 25, "s5c_low");
        hold(1'b1, L + 1, "s5d_high");
        hold(1'b0, 25, "s5d_low");
        // 6: reset in the middle of a hold, button kept pressed
        hold(1'b1, 16, "s6_hold");
        pulse_reset(2, 1'b1, "s6_rst");
        hold(1'b1, 25, "s6_after");
        hold(1'b0, 25, "s6_low");

        // Random gestures with occasional resets
        for (int k = 0; k < 60; k++) begin
            hold(1'b1, int'($urandom_range(26, 1)), "rnd_high");
            if ($urandom_range(9, 0) == 0)
                pulse_reset(int'($urandom_range(3, 1)), 1'($urandom_range(1, 0)), "rnd_rst");
            hold(1'b0, int'($urandom_range(14, 1)), "rnd_low");
        end
        hold(1'b0, 25, "final_low");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_button_event_decoder

// File: doc/button_event_decoder.md
# button_event_decoder

Consumes the debounced push-button level from the debouncer stage and classifies the button's activity into single-cycle event pulses: press, release, short press, long press and (optionally) double press. It sits directly downstream of the debouncer, in the same clock domain. It feeds mode/control logic that must react to gestures rather than raw levels.

## Interface
- `LONG_CYCLES`, 100000000: press duration in clock cycles that qualifies as a long press (1 s at 100 MHz).
- `GAP_CYCLES`, 30000000: maximum release-to-second-press gap in cycles for a double press.
- `CNT_W`, 27: counter width; must satisfy 2^CNT_W > max(LONG_CYCLES, GAP_CYCLES).
- `clk` in 1: single clock, shared with the debouncer.
- `rst` in 1: reset, asynchronous, active-high.
- `pb_state` in 1: debounced button level, 1 = pressed; synchronous to `clk`.
- `press` out 1: one-cycle pulse on a 0→1 edge of `pb_state`.
- `release` out 1: one-cycle pulse on a 1→0 edge of `pb_state`.
- `short_press` out 1: one-cycle pulse for a completed short single press.
- `long_press` out 1: one-cycle pulse when a hold reaches `LONG_CYCLES`.
- `double_press` out 1: one-cycle pulse on the second press of a double press. Tied to 0 when the feature is compiled out.
- `held` out 1: level, 1 while the FSM is in LONG_HELD.

## Operation
- Edge detection:
  - `pb_d` register tracks `pb_state` and resets to 0.
  - rise = `pb_state` & ~`pb_d`; fall = ~`pb_state` & `pb_d`.
  - A button held through reset release therefore yields a `press` event. This is intended.
- FSM states: IDLE, PRESSED, LONG_HELD, GAP, SECOND. The state register and `cnt` reset to IDLE and 0.
- IDLE:
  - On rise: go to PRESSED, `cnt`←0.
- PRESSED: `cnt` increments each cycle.
  - On fall, with double-press enabled: go to GAP, `cnt`←0.
  - On fall, with double-press disabled: pulse `short_press`, go to IDLE.
  - Otherwise, if `cnt` == LONG_CYCLES-1: pulse `long_press`, go to LONG_HELD.
  - Fall and terminal count in the same cycle: fall wins, so the press is short.
- LONG_HELD:
  - `held`=1.
  - On fall: go to IDLE. No further events except `release`.
- GAP: `cnt` increments each cycle.
  - On rise: pulse `double_press`, go to SECOND.
  - Otherwise, if `cnt` == GAP_CYCLES-1: pulse `short_press`, go to IDLE.
  - Rise and terminal count in the same cycle: rise wins, so the event is a double press.
- SECOND:
  - Long timing is not applied.
  - On fall: go to IDLE.
- `press` and `release` pulse on every edge, independent of state.
- Gesture outputs are mutually exclusive per cycle.
- Counter: unsigned `CNT_W`-bit; it never wraps because it is cleared or exits at its terminal values.

## Timing
- All outputs are registered, and all reset to 0.
- `press`/`release` are high for exactly the one cycle following the clock edge at which `pb_state` is first sampled at its new value (latency 1).
- `long_press` asserts exactly `LONG_CYCLES` cycles after `press` asserts, if `pb_state` stays high throughout.
- Short press:
  - Double-press disabled: `short_press` asserts in the same cycle as the corresponding `release`.
  - Double-press enabled: `short_press` asserts `GAP_CYCLES` cycles after `release`.
- `double_press` asserts in the same cycle as the second `press`.
- `held` rises in the cycle `long_press` asserts and falls in the cycle `release` asserts.
- Reset mid-operation: all outputs deassert immediately (asynchronously). No pending event is emitted after reset.

## Configuration
- `BUTTON_DOUBLE_PRESS_EN` defined:
  - GAP and SECOND states are present.
  - Short presses are reported only after the gap expires.
- `BUTTON_DOUBLE_PRESS_EN` undefined:
  - GAP and SECOND states are absent.
  - `short_press` fires at release.
  - `double_press` is constant 0.
  - `GAP_CYCLES` is unused.

## Structure
- Shared package `button_evt_pkg` holds:
  - the FSM state encoding (3-bit localparams IDLE=0, PRESSED=1, LONG_HELD=2, GAP=3, SECOND=4);
  - default timing constants (`LONG_CYCLES`, `GAP_CYCLES`, `CNT_W`).
- One sub-module `edge_detect` (clk, rst, level in; rise, fall out) holds the `pb_d` register. The FSM and counter live in the top.

## Test plan
All scenarios use LONG_CYCLES=20, GAP_CYCLES=10, CNT_W=5.
1. Macro off, hold `pb_state` high 5 cycles then low → `press` 1 cycle after rise; `release` and `short_press` together 1 cycle after fall; no `long_press`.
2. Hold high 30 cycles → `long_press` exactly 20 cycles after `press`; `held` high until `release`; no `short_press`.
3. Macro on, press 5, release 4, press 5, release → `double_press` coincident with 2nd `press`; no `short_press`.
4. Macro on, press 5 then release → `short_press` exactly 10 cycles after `release`.
5. Macro on, second rise lands on the gap-terminal cycle (`cnt`=9) → `double_press`, no `short_press`; fall on the long-terminal cycle (`cnt`=19) → short-press path, no `long_press`.
6. Assert `rst` at `cnt`=15 of a hold, release after 2 cycles with `pb_state` still high → all outputs 0 during reset; then `press` 1 cycle after reset release; `long_press` 20 cycles later.
